lsu_mem_port: RTL and testbench

- Load/store unit between the execute stage and the data-memory bus.
- Store direction: steers byte and halfword store data onto the correct lanes of a 32-bit word bus and generates the matching write strobes.
- Load direction: picks the addressed lane out of the returned word, then sign- or zero-extends it before it reaches the writeback select.
- Runs a valid/ready handshake on both the core side and the memory side. Each request is multi-cycle, with one request in flight at a time.

---
 rtl/lsu_mem_port_if.sv | 48 ++++
 rtl/lsu_mem_port.sv | 153 +++++++++++++++
 tb/tb_lsu_mem_port.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_mem_port_if.sv
// ============================================================================
// Module   : lsu_mem_port_if
// Brief    : Core-side request/response and memory-bus signal bundle for the LSU.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface lsu_mem_port_if #(
    parameter int XLEN = 32
);
    logic            req_valid;
    logic            req_ready;
    logic            req_we;
    logic [2:0]      req_funct3;
    logic [XLEN-1:0] req_addr;
    logic [XLEN-1:0] req_wdata;

    logic            mem_valid;
    logic            mem_ready;
    logic [XLEN-1:0] mem_addr;
    logic            mem_we;
    logic [3:0]      mem_wstrb;
    logic [XLEN-1:0] mem_wdata;
    logic            mem_rvalid;
    logic [XLEN-1:0] mem_rdata;

    logic            rsp_valid;
    logic [XLEN-1:0] rsp_rdata;
    logic            rsp_err;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  mem_ready, mem_rvalid, mem_rdata,
        output req_ready,
        output mem_valid, mem_addr, mem_we, mem_wstrb, mem_wdata,
        output rsp_valid, rsp_rdata, rsp_err
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        output mem_ready, mem_rvalid, mem_rdata,
        input  req_ready,
        input  mem_valid, mem_addr, mem_we, mem_wstrb, mem_wdata,
        input  rsp_valid, rsp_rdata, rsp_err
    );
endinterface

`default_nettype wire

// File: rtl/lsu_mem_port.sv
// ============================================================================
// Module   : lsu_mem_port
// Brief    : Load/store unit: lane steering, load extension, one request in flight.
// Revision : 1.0
// ============================================================================
`default_nettype none

module lsu_mem_port #(
    parameter int XLEN = 32
) (
    input  wire logic       clk,
    input  wire logic       reset,
    lsu_mem_port_if.slave   bus
);
    localparam logic [2:0] c_f3_b  = 3'b000;
    localparam logic [2:0] c_f3_h  = 3'b001;
    localparam logic [2:0] c_f3_w  = 3'b010;
    localparam logic [2:0] c_f3_bu = 3'b100;
    localparam logic [2:0] c_f3_hu = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t          r_state;
    logic [2:0]      r_funct3;
    logic [1:0]      r_lane;

    logic            w_illegal;
    logic [3:0]      w_wstrb;
    logic [XLEN-1:0] w_wdata;
    logic [XLEN-1:0] w_shifted;
    logic [XLEN-1:0] w_ext;

    assign bus.req_ready = (r_state == S_IDLE);

    always_comb begin
        w_illegal = 1'b0;
        case (bus.req_funct3)
            c_f3_b, c_f3_bu: w_illegal = 1'b0;
            c_f3_h, c_f3_hu: w_illegal = bus.req_addr[0];
            c_f3_w:          w_illegal = |bus.req_addr[1:0];
            default:         w_illegal = 1'b1;
        endcase
        // Unsigned variants only exist for loads
        if (bus.req_we && (bus.req_funct3 == c_f3_bu || bus.req_funct3 == c_f3_hu)) begin
            w_illegal = 1'b1;
        end
    end

    always_comb begin
        w_wstrb = 4'b0000;
        w_wdata = '0;
        if (bus.req_we) begin
            case (bus.req_funct3[1:0])
                2'b00: begin
                    w_wstrb = 4'b0001 << bus.req_addr[1:0];
                    w_wdata = {4{bus.req_wdata[7:0]}};
                end
                2'b01: begin
                    w_wstrb = 4'b0011 << {bus.req_addr[1], 1'b0};
                    w_wdata = {2{bus.req_wdata[15:0]}};
                end
                default: begin
                    w_wstrb = 4'b1111;
                    w_wdata = bus.req_wdata;
                end
            endcase
        end
    end

    // Bring the addressed lane down to bit 0 before extending
    assign w_shifted = bus.mem_rdata >> {r_lane, 3'b000};

    always_comb begin
        w_ext = w_shifted;
        case (r_funct3)
            c_f3_b:  w_ext = {{(XLEN-8){w_shifted[7]}}, w_shifted[7:0]};
            c_f3_bu: w_ext = {{(XLEN-8){1'b0}}, w_shifted[7:0]};
            c_f3_h:  w_ext = {{(XLEN-16){w_shifted[15]}}, w_shifted[15:0]};
            c_f3_hu: w_ext = {{(XLEN-16){1'b0}}, w_shifted[15:0]};
            default: w_ext = w_shifted;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_funct3      <= 3'b000;
            r_lane        <= 2'b00;
            bus.mem_valid <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_wstrb <= 4'b0000;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= '0;
            bus.rsp_err   <= 1'b0;
        end else begin
            bus.rsp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        r_funct3 <= bus.req_funct3;
                        r_lane   <= bus.req_addr[1:0];
                        if (w_illegal) begin
                            r_state       <= S_RESP;
                            bus.rsp_valid <= 1'b1;
                            bus.rsp_err   <= 1'b1;
                            bus.rsp_rdata <= '0;
                        end else begin
                            r_state       <= S_REQ;
                            bus.mem_valid <= 1'b1;
                            bus.mem_addr  <= {bus.req_addr[XLEN-1:2], 2'b00};
                            bus.mem_we    <= bus.req_we;
                            bus.mem_wstrb <= w_wstrb;
                            bus.mem_wdata <= w_wdata;
                        end
                    end
                end
                S_REQ: begin
                    if (bus.mem_ready) begin
                        bus.mem_valid <= 1'b0;
                        if (bus.mem_we) begin
                            r_state       <= S_RESP;
                            bus.rsp_valid <= 1'b1;
                            bus.rsp_err   <= 1'b0;
                            bus.rsp_rdata <= '0;
                        end else begin
                            r_state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (bus.mem_rvalid) begin
                        r_state       <= S_RESP;
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_err   <= 1'b0;
                        bus.rsp_rdata <= w_ext;
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_lsu_mem_port.sv
// ============================================================================
// Module   : tb_lsu_mem_port
// Brief    : Directed bench for lsu_mem_port with a response scoreboard.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_lsu_mem_port;
    logic clk;
    logic reset;
    int   total;
    int   bad;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;
    exp_t sb[$];

    lsu_mem_port_if #(.XLEN(32)) bus ();

    lsu_mem_port #(.XLEN(32)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drives one request, plays the memory, and scores the response.
    task automatic run_req(
        input string       tag,
        input logic        we,
        input logic [2:0]  f3,
        input logic [31:0] addr,
        input logic [31:0] wdata,
        input logic [31:0] rdata,
        input int          rdy_dly,
        input int          rv_dly,
        input logic [31:0] exp_maddr,
        input logic [3:0]  exp_strb,
        input logic [31:0] exp_mwdata,
        input logic [31:0] exp_rdata,
        input logic        exp_err,
        input int          exp_lat,
        input bit          poke_busy
    );
        int   cyc;
        int   rdy_cnt;
        int   rv_cnt;
        bit   done;
        bit   hs;
        bit   hs_edge;
        bit   saw_mv;
        exp_t e;
        sb.push_back('{rdata: exp_rdata, err: exp_err});
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        @(negedge clk);
        check({tag, "_req_ready"}, bus.req_ready, 1);
        @(posedge clk); #1;
        bus.req_valid = poke_busy;
        if (poke_busy) begin
            bus.req_addr  = 32'hDEAD_0001;
            bus.req_wdata = 32'h5555_AAAA;
        end
        cyc = 2; rdy_cnt = 0; rv_cnt = 0; done = 0; hs = 0; saw_mv = 0;
        while (!done && cyc < 60) begin
            bus.mem_ready  = 1'b0;
            bus.mem_rvalid = 1'b0;
            if (bus.rsp_valid) begin
                done = 1;
                bus.req_valid = 1'b0;
                check({tag, "_sb_nonempty"}, sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check({tag, "_rdata"}, bus.rsp_rdata, e.rdata);
                    check({tag, "_err"}, bus.rsp_err, e.err);
                end
                check({tag, "_latency"}, cyc, exp_lat);
            end else begin
                if (poke_busy) check({tag, "_busy_ready"}, bus.req_ready, 0);
                if (bus.mem_valid) begin
                    saw_mv = 1;
                    check({tag, "_maddr"}, bus.mem_addr, exp_maddr);
                    check({tag, "_mwe"}, bus.mem_we, we);
                    check({tag, "_wstrb"}, bus.mem_wstrb, exp_strb);
                    if (we) check({tag, "_mwdata"}, bus.mem_wdata, exp_mwdata);
                    bus.mem_ready = (rdy_cnt >= rdy_dly);
                    rdy_cnt++;
                end
                if (hs && !we) begin
                    if (rv_cnt == rv_dly) begin
                        bus.mem_rvalid = 1'b1;
                        bus.mem_rdata  = rdata;
                    end
                    rv_cnt++;
                end
            end
            hs_edge = bus.mem_valid && bus.mem_ready;
            if (!done) begin
                @(posedge clk); #1;
                cyc++;
                if (hs_edge) hs = 1;
            end
        end
        if (!done) check({tag, "_timeout"}, 0, 1);
        check({tag, "_mem_valid_seen"}, saw_mv, !exp_err);
        @(posedge clk); #1;
        check({tag, "_rsp_one_cycle"}, bus.rsp_valid, 0);
        check({tag, "_back_idle"}, bus.req_ready, 1);
    endtask

    initial begin
        logic [31:0] exp_bu [4];
        logic [31:0] exp_b  [4];
        total = 0;
        bad   = 0;
        clk   = 1'b0;
        reset = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.mem_ready  = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
        exp_bu = '{32'h0000_00F0, 32'h0000_00E0, 32'h0000_00C0, 32'h0000_0080};
        exp_b  = '{32'hFFFF_FFF0, 32'hFFFF_FFE0, 32'hFFFF_FFC0, 32'hFFFF_FF80};

        repeat (3) @(posedge clk);
        #1;
        check("rst_mem_valid", bus.mem_valid, 0);
        check("rst_mem_we", bus.mem_we, 0);
        check("rst_mem_wstrb", bus.mem_wstrb, 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        check("rst_mem_wdata", bus.mem_wdata, 0);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_rsp_rdata", bus.rsp_rdata, 0);
        check("rst_rsp_err", bus.rsp_err, 0);
        check("rst_req_ready", bus.req_ready, 1);
        reset = 1'b0;
        @(posedge clk); #1;

        run_req("st_b", 1, 3'b000, 32'h0000_1003, 32'h0000_00AB, 0, 0, 0,
                32'h0000_1000, 4'b1000, 32'hABAB_ABAB, 32'h0, 0, 3, 0);
        run_req("ld_h", 0, 3'b001, 32'h0000_2002, 0, 32'h8001_1234, 0, 1,
                32'h0000_2000, 4'b0000, 0, 32'hFFFF_8001, 0, 5, 0);
        run_req("ld_hu", 0, 3'b101, 32'h0000_2002, 0, 32'h8001_1234, 0, 1,
                32'h0000_2000, 4'b0000, 0, 32'h0000_8001, 0, 5, 0);
        run_req("st_w_misal", 1, 3'b010, 32'h0000_3001, 32'h1111_2222, 0, 0, 0,
                0, 4'b0000, 0, 32'h0, 1, 2, 0);
        run_req("st_w_bp", 1, 3'b010, 32'h0000_4000, 32'h1234_5678, 0, 5, 0,
                32'h0000_4000, 4'b1111, 32'h1234_5678, 32'h0, 0, 8, 1);
        run_req("st_h_hi", 1, 3'b001, 32'h0000_7002, 32'h0000_BEEF, 0, 0, 0,
                32'h0000_7000, 4'b1100, 32'hBEEF_BEEF, 32'h0, 0, 3, 0);
        run_req("ld_w", 0, 3'b010, 32'h0000_7004, 0, 32'hCAFE_F00D, 0, 0,
                32'h0000_7004, 4'b0000, 0, 32'hCAFE_F00D, 0, 4, 0);
        run_req("st_bu_illegal", 1, 3'b100, 32'h0000_7000, 32'h0000_0011, 0, 0, 0,
                0, 4'b0000, 0, 32'h0, 1, 2, 0);
        run_req("ld_f3_011", 0, 3'b011, 32'h0000_7000, 0, 0, 0, 0,
                0, 4'b0000, 0, 32'h0, 1, 2, 0);
        run_req("ld_h_misal", 0, 3'b001, 32'h0000_7001, 0, 0, 0, 0,
                0, 4'b0000, 0, 32'h0, 1, 2, 0);

        for (int i = 0; i < 4; i++) begin
            run_req($sformatf("ld_bu_lane%0d", i), 0, 3'b100, 32'h0000_6000 + i, 0,
                    32'h80C0_E0F0, 0, 0, 32'h0000_6000, 4'b0000, 0, exp_bu[i], 0, 4, 0);
            run_req($sformatf("ld_b_lane%0d", i), 0, 3'b000, 32'h0000_6000 + i, 0,
                    32'h80C0_E0F0, 0, 0, 32'h0000_6000, 4'b0000, 0, exp_b[i], 0, 4, 0);
        end

        // Abandon a load sitting in WAIT; the stale read data must not surface
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'b010;
        bus.req_addr   = 32'h0000_5000;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        check("rstmid_mem_valid", bus.mem_valid, 1);
        bus.mem_ready = 1'b1;
        @(posedge clk); #1;
        bus.mem_ready = 1'b0;
        check("rstmid_in_wait_mv", bus.mem_valid, 0);
        check("rstmid_in_wait_ready", bus.req_ready, 0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("rstmid_after_mv", bus.mem_valid, 0);
        check("rstmid_after_ready", bus.req_ready, 1);
        check("rstmid_after_rsp", bus.rsp_valid, 0);
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h0BAD_0BAD;
        @(posedge clk); #1;
        bus.mem_rvalid = 1'b0;
        repeat (3) begin
            check("rstmid_no_rsp", bus.rsp_valid, 0);
            check("rstmid_idle", bus.req_ready, 1);
            @(posedge clk); #1;
        end
        check("sb_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

`default_nettype wire
